// File: rtl/mac_fp52_pkg.sv
// Shared operand/result definitions for the fp52 multiply-accumulate scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package mac_fp52_pkg;

  localparam int OP_W  = 10;
  localparam int RES_W = 18;

  // Bit positions inside one 10-bit operand.
  localparam int OP_SIGN   = 9;
  localparam int OP_DENORM = 8;
  localparam int OP_EXP_HI = 7;
  localparam int OP_EXP_LO = 5;
  localparam int OP_MAN_HI = 4;
  localparam int OP_MAN_LO = 0;

  typedef struct packed {
    logic       sign;
    logic       denorm;
    logic [2:0] exp;
    logic [4:0] man;
  } op_t;

  // One requester slice is {op_c, op_b, op_a}.
  typedef struct packed {
    op_t c;
    op_t b;
    op_t a;
  } triple_t;

  localparam int TRIPLE_W = 3 * OP_W;

endpackage

// File: rtl/mac_fp52_res_fifo.sv
// Circular result FIFO with show-ahead head output and occupancy count.
// Latency: a push is visible on head/valid the cycle after it is written.
// Backpressure: none internally; the caller's credit scheme keeps it from overflowing.
module mac_fp52_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_pop;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign do_pop = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  // Head is forced to zero when empty so stale entries never show.
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mac_fp52_sched.sv
// Round-robin sharing of one mul_fp52 MAC pipeline between NUM_REQ requesters.
// Latency: handshake cycle t -> dp_op at t+1 -> capture at t+1+PIPE_LAT -> res_valid at t+2+PIPE_LAT.
// Backpressure: issue is credit-gated on FIFO + in-flight occupancy, so results are never dropped.
module mac_fp52_sched
  import mac_fp52_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int PIPE_LAT  = 3,
  parameter int RES_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*TRIPLE_W-1:0]  req_op,
  output logic [OP_W-1:0]              dp_op_a,
  output logic [OP_W-1:0]              dp_op_b,
  output logic [OP_W-1:0]              dp_op_c,
  input  logic [RES_W-1:0]             dp_res,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RES_W-1:0]             res_data,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(RES_DEPTH) + 1;

  logic [IDW-1:0]       rr_ptr;
  logic [CW-1:0]        inflight_count;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          credit_used;
  logic                 can_issue;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       grant_id;
  logic                 grant_any;
  triple_t              grant_op;
  triple_t              issue_op;
  logic                 issue_vld;
  logic [IDW-1:0]       issue_id;
  logic [PIPE_LAT-1:0]  tag_vld;
  logic [IDW-1:0]       tag_id [PIPE_LAT];
  logic                 capture;
  logic [IDW+RES_W-1:0] head;

  // Every issued triple holds one FIFO slot from issue until it is popped.
  // A pop frees its slot only once the registered count has dropped.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign can_issue   = credit_used < (CW+1)'(RES_DEPTH);

  // Round-robin search beginning just after the previous winner.
  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (can_issue) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        if (!grant_any && req_valid[idx]) begin
          grant_any   = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = idx;
        end
      end
    end
  end

  assign req_ready = grant;
  assign grant_op  = triple_t'(req_op[int'(grant_id)*TRIPLE_W +: TRIPLE_W]);

  // Issue register: winner's triple goes to the datapath, otherwise a zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_op  <= '0;
      issue_vld <= 1'b0;
      issue_id  <= '0;
    end else begin
      issue_vld <= grant_any;
      issue_id  <= grant_any ? grant_id : '0;
      issue_op  <= grant_any ? grant_op : '0;
    end
  end

  assign dp_op_a = issue_op.a;
  assign dp_op_b = issue_op.b;
  assign dp_op_c = issue_op.c;

  // Tag pipe follows each triple so the last stage lines up with its dp_res.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= issue_vld;
      tag_id[0]  <= issue_id;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign capture = tag_vld[PIPE_LAT-1];

  // Remember the last winner; reset points at the top so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= IDW'(NUM_REQ - 1);
    else if (grant_any) rr_ptr <= grant_id;
  end

  // Triples between handshake and capture; issue and capture together cancel.
  always_ff @(posedge clk) begin
    if (rst)                          inflight_count <= '0;
    else if (grant_any && !capture)   inflight_count <= inflight_count + 1'b1;
    else if (!grant_any && capture)   inflight_count <= inflight_count - 1'b1;
  end

  mac_fp52_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (IDW + RES_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data ({tag_id[PIPE_LAT-1], dp_res}),
    .pop       (res_ready),
    .valid     (res_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign res_id   = head[RES_W +: IDW];
  assign res_data = head[RES_W-1:0];
  assign busy     = issue_vld | (|tag_vld) | (fifo_count != '0);

  a_fifo_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CW'(RES_DEPTH));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit_used <= (CW+1)'(RES_DEPTH));

endmodule

// File: tb/tb_mac_fp52_sched.sv
// Scoreboard bench for mac_fp52_sched with a transaction-level reference model.
// Latency: model predicts dp_op one cycle after a grant and results PIPE_LAT+1 cycles after dp_op.
// Backpressure: res_ready is randomized or held low per phase to exercise the credit limit.
module tb_mac_fp52_sched;
  import mac_fp52_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int PIPE_LAT  = 3;
  localparam int RES_DEPTH = 4;
  localparam int IDW       = 2;
  localparam int TW        = TRIPLE_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*TW-1:0]   req_op = '0;
  logic [OP_W-1:0]         dp_op_a, dp_op_b, dp_op_c;
  logic [RES_W-1:0]        dp_res = '0;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [RES_W-1:0]        res_data;
  logic [IDW-1:0]          res_id;
  logic                    busy;

  mac_fp52_sched #(
    .NUM_REQ   (NUM_REQ),
    .PIPE_LAT  (PIPE_LAT),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .dp_op_a   (dp_op_a),
    .dp_op_b   (dp_op_b),
    .dp_op_c   (dp_op_c),
    .dp_res    (dp_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state: queues of transactions, not register images.
  typedef struct { int cap; int id; } inf_t;
  typedef struct packed { logic [IDW-1:0] id; logic [RES_W-1:0] data; } exp_t;

  inf_t             inflight_q[$];
  exp_t             exp_q[$];
  int               grant_log[$];
  int               m_fifo_n, mrr, m_occ, m_g, m_idx, hs_count;
  logic [TW-1:0]    exp_dp;
  logic [RES_W-1:0] m_val;
  logic             sched_vld [16] = '{default: 1'b0};
  logic [RES_W-1:0] sched_val [16];

  // Stimulus knobs.
  logic [NUM_REQ-1:0] en_mask;
  int                 p_valid, rdy_pct;
  bit                 done;
  int                 cnt[NUM_REQ];

  // Cycle counter and datapath model: scheduled results appear in their slot,
  // every other cycle carries garbage that must never be captured.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (sched_vld[cyc % 16]) begin
      dp_res = sched_val[cyc % 16];
      sched_vld[cyc % 16] = 1'b0;
    end else begin
      dp_res = RES_W'($urandom);
    end
  end

  // Reference model: predict grants, datapath operands, occupancy; push expected results.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mrr      = NUM_REQ - 1;
      m_fifo_n = 0;
      exp_dp   = '0;
      inflight_q.delete();
      exp_q.delete();
    end else begin
      m_occ = inflight_q.size() + m_fifo_n;
      m_g   = -1;
      if (m_occ < RES_DEPTH) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          m_idx = (mrr + k) % NUM_REQ;
          if (m_g < 0 && req_valid[m_idx] === 1'b1) m_g = m_idx;
        end
      end
      check("req_ready", 32'(req_ready), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
      check("dp_op", 32'({dp_op_c, dp_op_b, dp_op_a}), 32'(exp_dp));
      check("res_valid", 32'(res_valid), 32'(m_fifo_n != 0));
      check("busy", 32'(busy), 32'(m_occ != 0));
      if (res_ready && m_fifo_n > 0) m_fifo_n--;
      if (inflight_q.size() > 0 && inflight_q[0].cap == cyc) begin
        void'(inflight_q.pop_front());
        m_fifo_n++;
      end
      exp_dp = '0;
      if (m_g >= 0) begin
        m_val = RES_W'($urandom);
        sched_vld[(cyc + 1 + PIPE_LAT) % 16] = 1'b1;
        sched_val[(cyc + 1 + PIPE_LAT) % 16] = m_val;
        inflight_q.push_back('{cap: cyc + 1 + PIPE_LAT, id: m_g});
        exp_q.push_back('{id: IDW'(m_g), data: m_val});
        exp_dp = req_op[m_g*TW +: TW];
        mrr = m_g;
        grant_log.push_back(m_g);
        hs_count++;
      end
    end
  end

  // Monitor: whenever the DUT presents a result, compare with the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: actual data 0x%0h id %0d, required no result", res_data, res_id);
      end else begin
        check("res_data", 32'(res_data), 32'(exp_q[0].data));
        check("res_id", 32'(res_id), 32'(exp_q[0].id));
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of requester behaviour: a valid is held until accepted.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i] || !req_valid[i]) begin
        if (en_mask[i] && $urandom_range(99) < p_valid) begin
          req_valid[i] = 1'b1;
          req_op[i*TW +: TW] = TW'($urandom);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    res_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_mask   = '0;
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    en_mask = '0;
    p_valid = 100;
    rdy_pct = 100;
    repeat (3) step();
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_dp_op", 32'({dp_op_c, dp_op_b, dp_op_a}), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_res_id", 32'(res_id), 0);
    resync();

    // Single issue from requester 0 with fixed operands.
    grant_log.delete();
    req_op[0 +: TW] = {1'b0, 1'b1, 3'd3, 5'd0, 1'b0, 1'b1, 3'd1, 5'd31, 1'b0, 1'b1, 3'd1, 5'd31};
    req_valid[0] = 1'b1;
    repeat (10) step();
    check("single_grants", 32'(grant_log.size()), 1);
    check("single_id", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 0);

    // Round robin with all requesters valid.
    do_reset();
    grant_log.delete();
    en_mask = '1;
    p_valid = 100;
    rdy_pct = 100;
    repeat (30) step();
    for (int k = 0; k < 6; k++)
      check("rr_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF, 32'(k % NUM_REQ));
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    foreach (grant_log[k]) cnt[grant_log[k]]++;
    for (int i = 0; i < NUM_REQ; i++) check("rr_no_starve", 32'(cnt[i] > 0), 1);

    // Back-pressure: drain, then fill with res_ready held low.
    en_mask = '0;
    rdy_pct = 100;
    repeat (20) step();
    req_valid = '0;
    rdy_pct   = 0;
    res_ready = 1'b0;
    en_mask   = 4'b0110;
    hs_count  = 0;
    repeat (15) step();
    check("bp_handshakes", 32'(hs_count), 4);
    hs_count = 0;
    rdy_pct  = 100;
    step();
    rdy_pct  = 0;
    repeat (10) step();
    check("bp_one_credit", 32'(hs_count), 1);

    // Bubbles: nothing valid, datapath must see zeros, then busy falls.
    en_mask   = '0;
    req_valid = '0;
    rdy_pct   = 100;
    res_ready = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bubble_dp_op", 32'({dp_op_c, dp_op_b, dp_op_a}), 0);
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    check("busy_drain", 32'(busy), 0);
    resync();

    // Reset with two triples in flight and one held in the FIFO.
    rdy_pct   = 0;
    res_ready = 1'b0;
    en_mask   = '1;
    hs_count  = 0;
    for (int k = 0; k < 20 && hs_count < 3; k++) step();
    en_mask   = '0;
    req_valid = '0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (m_fifo_n == 1 && inflight_q.size() == 2) done = 1'b1;
      else step();
    end
    check("midop_state_reached", 32'(done), 1);
    do_reset();
    @(negedge clk);
    check("midop_res_valid", 32'(res_valid), 0);
    check("midop_busy", 32'(busy), 0);
    resync();
    repeat (8) step();
    grant_log.delete();
    en_mask = '1;
    p_valid = 100;
    rdy_pct = 100;
    repeat (3) step();
    check("midop_restart_id", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 0);

    // Random traffic with random consumer stalls.
    p_valid = 40;
    rdy_pct = 60;
    repeat (400) step();

    // Drain everything.
    en_mask = '0;
    rdy_pct = 100;
    repeat (40) step();
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
